// File: rtl/stage4_mem_pkg.sv
// rtl/stage4_mem_pkg.sv - shared width default and memory-access FSM encoding for stage4_mem
package stage4_mem_pkg;
  localparam int DW = 32;

  typedef enum logic {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/stage4_mem_fsm.sv
// rtl/stage4_mem_fsm.sv - mem_access_fsm: req/ack data-memory handshake, request registers and stall
module mem_access_fsm
  import stage4_mem_pkg::*;
#(
  parameter int W = DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_op,
  input  logic         mem_wr,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] wdata,
  input  logic         dmem_ack,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [W-1:0] dmem_addr,
  output logic [W-1:0] dmem_wdata,
  output logic         mem_stall,
  output logic         done
);
  mem_state_t   state, state_next;
  logic         req_next, we_next;
  logic [W-1:0] addr_next, wdata_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MEM_ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      state      <= state_next;
      dmem_req   <= req_next;
      dmem_we    <= we_next;
      dmem_addr  <= addr_next;
      dmem_wdata <= wdata_next;
    end
  end

  // Request fields are captured once in IDLE and held untouched for the whole WAIT.
  always_comb begin
    state_next = state;
    req_next   = dmem_req;
    we_next    = dmem_we;
    addr_next  = dmem_addr;
    wdata_next = dmem_wdata;
    mem_stall  = 1'b0;
    done       = 1'b0;
    case (state)
      MEM_ST_IDLE: begin
        if (mem_op) begin
          addr_next  = addr;
          wdata_next = wdata;
          we_next    = mem_wr;
          req_next   = 1'b1;
          state_next = MEM_ST_WAIT;
          mem_stall  = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      MEM_ST_WAIT: begin
        if (dmem_ack) begin
          req_next   = 1'b0;
          we_next    = 1'b0;
          state_next = MEM_ST_IDLE;
          done       = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_next = MEM_ST_IDLE;
    endcase
  end
endmodule

// File: rtl/stage4_mem.sv
// rtl/stage4_mem.sv - pipeline memory stage: branch resolve, data-memory access, MEM/WB register
// Optional stall counter port and logic enabled by defining MEM_STALL_CNT_EN.
module stage4_mem
  import stage4_mem_pkg::*;
(
  input  logic          clk,
  input  logic          rstb,
  input  logic          valid,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] regB_rd_data,
  input  logic [4:0]    reg_wr_addr,
  input  logic          alu_zero,
  input  logic          alu_not_zero,
  input  logic          alu_greater,
  input  logic [DW-1:0] pc_plus4_plusimm16,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic          mem_to_reg,
  input  logic          reg_wr,
  input  logic          branch_eq,
  input  logic          branch_ne,
  input  logic          branch_gt,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          mem_stall,
  output logic          pc_src,
  output logic [DW-1:0] branch_target,
  output logic          if_flush,
  output logic          wb_reg_wr,
  output logic [4:0]    wb_reg_addr,
  output logic [DW-1:0] wb_data
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0]   stall_count
`endif
);
  logic mem_op;
  logic done;
  logic branch_cond;

  assign mem_op = valid & (mem_rd | mem_wr);

  mem_access_fsm #(.W(DW)) u_fsm (
    .clk       (clk),
    .rst       (rstb),
    .mem_op    (mem_op),
    .mem_wr    (mem_wr),
    .addr      (alu_result),
    .wdata     (regB_rd_data),
    .dmem_ack  (dmem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .mem_stall (mem_stall),
    .done      (done)
  );

  assign branch_cond   = (branch_eq & alu_zero) | (branch_ne & alu_not_zero) |
                         (branch_gt & alu_greater);
  assign pc_src        = valid & ~mem_stall & branch_cond;
  assign if_flush      = pc_src;
  assign branch_target = pc_plus4_plusimm16;

  // A stalled cycle inserts a bubble; address and data keep their last completed values.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      wb_reg_wr   <= 1'b0;
      wb_reg_addr <= '0;
      wb_data     <= '0;
    end else if (done) begin
      wb_reg_wr   <= valid & reg_wr;
      wb_reg_addr <= reg_wr_addr;
      wb_data     <= mem_to_reg ? dmem_rdata : alu_result;
    end else begin
      wb_reg_wr   <= 1'b0;
    end
  end

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      stall_count <= '0;
    end else if (mem_stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_stage4_mem.sv
// tb/tb_stage4_mem.sv - self-checking bench for stage4_mem (optionally built with MEM_STALL_CNT_EN)
module tb_stage4_mem;
  logic        clk = 1'b0;
  logic        rstb;
  logic        valid, alu_zero, alu_not_zero, alu_greater;
  logic [31:0] alu_result, regB_rd_data, pc_plus4_plusimm16, dmem_rdata;
  logic [4:0]  reg_wr_addr;
  logic        mem_rd, mem_wr, mem_to_reg, reg_wr, branch_eq, branch_ne, branch_gt, dmem_ack;
  logic        dmem_req, dmem_we, mem_stall, pc_src, if_flush, wb_reg_wr;
  logic [31:0] dmem_addr, dmem_wdata, branch_target, wb_data;
  logic [4:0]  wb_reg_addr;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int model_stalls = 0;
  logic [31:0] mem_model [int unsigned];

  always #5 clk = ~clk;

  stage4_mem dut (
    .clk(clk), .rstb(rstb), .valid(valid), .alu_result(alu_result),
    .regB_rd_data(regB_rd_data), .reg_wr_addr(reg_wr_addr), .alu_zero(alu_zero),
    .alu_not_zero(alu_not_zero), .alu_greater(alu_greater),
    .pc_plus4_plusimm16(pc_plus4_plusimm16), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .branch_gt(branch_gt), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .pc_src(pc_src), .branch_target(branch_target),
    .if_flush(if_flush), .wb_reg_wr(wb_reg_wr), .wb_reg_addr(wb_reg_addr), .wb_data(wb_data)
`ifdef MEM_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    valid = 0; alu_result = 0; regB_rd_data = 0; reg_wr_addr = 0;
    alu_zero = 0; alu_not_zero = 0; alu_greater = 0; pc_plus4_plusimm16 = 0;
    mem_rd = 0; mem_wr = 0; mem_to_reg = 0; reg_wr = 0;
    branch_eq = 0; branch_ne = 0; branch_gt = 0; dmem_rdata = 0; dmem_ack = 0;
  endtask

  // Entered and left at a falling edge; the instruction is held until it completes.
  task automatic run_alu(input logic [4:0] rd, input logic [31:0] res, input bit rw);
    clear_inputs();
    valid = 1; reg_wr = rw; reg_wr_addr = rd; alu_result = res;
    dmem_ack = 1'($urandom);
    #1;
    n_checks++; if (mem_stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", mem_stall); else n_pass++;
    @(posedge clk); @(negedge clk);
    n_checks++; if (wb_reg_wr !== rw) $display("FAIL alu_wb_wr: got %b want %b", wb_reg_wr, rw); else n_pass++;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL alu_req: got %b want 0", dmem_req); else n_pass++;
    if (rw) begin
      n_checks++; if (wb_reg_addr !== rd) $display("FAIL alu_wb_addr: got %0d want %0d", wb_reg_addr, rd); else n_pass++;
      n_checks++; if (wb_data !== res) $display("FAIL alu_wb_data: got %h want %h", wb_data, res); else n_pass++;
    end
  endtask

  task automatic run_mem(input bit is_wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input bit m2r, input bit rw, input int d);
    int stalls;
    logic [31:0] rdata;
    stalls = 0;
    rdata = is_wr ? $urandom : (mem_model.exists(a) ? mem_model[a] : (32'h0BAD_0000 | a));
    clear_inputs();
    valid = 1; mem_rd = !is_wr; mem_wr = is_wr; alu_result = a; regB_rd_data = wd;
    reg_wr_addr = rd; mem_to_reg = m2r; reg_wr = rw;
    dmem_ack = 1'($urandom);
    #1;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL mem_req_gap: got %b want 0", dmem_req); else n_pass++;
    if (mem_stall) stalls++;
    @(posedge clk);
    for (int k = 0; k <= d; k++) begin
      @(negedge clk);
      n_checks++; if (dmem_req !== 1'b1) $display("FAIL mem_req_hold: got %b want 1", dmem_req); else n_pass++;
      n_checks++; if (dmem_addr !== a) $display("FAIL mem_addr: got %h want %h", dmem_addr, a); else n_pass++;
      n_checks++; if (dmem_we !== is_wr) $display("FAIL mem_we: got %b want %b", dmem_we, is_wr); else n_pass++;
      n_checks++; if (wb_reg_wr !== 1'b0) $display("FAIL mem_bubble: got %b want 0", wb_reg_wr); else n_pass++;
      if (is_wr) begin
        n_checks++; if (dmem_wdata !== wd) $display("FAIL mem_wdata: got %h want %h", dmem_wdata, wd); else n_pass++;
      end
      dmem_ack = (k == d);
      dmem_rdata = (k == d) ? rdata : $urandom;
      #1;
      if (mem_stall) stalls++;
      @(posedge clk);
    end
    @(negedge clk);
    dmem_ack = 0;
    n_checks++; if (stalls != d + 1) $display("FAIL mem_stall_cycles: got %0d want %0d", stalls, d + 1); else n_pass++;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL mem_req_drop: got %b want 0", dmem_req); else n_pass++;
    n_checks++; if (wb_reg_wr !== rw) $display("FAIL mem_wb_wr: got %b want %b", wb_reg_wr, rw); else n_pass++;
    if (rw) begin
      n_checks++; if (wb_reg_addr !== rd) $display("FAIL mem_wb_addr: got %0d want %0d", wb_reg_addr, rd); else n_pass++;
      n_checks++; if (wb_data !== (m2r ? rdata : a)) $display("FAIL mem_wb_data: got %h want %h", wb_data, m2r ? rdata : a); else n_pass++;
    end
    if (is_wr) mem_model[a] = wd;
    model_stalls += d + 1;
  endtask

  // kind: 0 eq, 1 ne, 2 gt, 3 none
  task automatic run_branch(input int kind, input bit z, input bit nz, input bit gt,
                            input logic [31:0] tgt, input bit v);
    bit taken;
    clear_inputs();
    valid = v; branch_eq = (kind == 0); branch_ne = (kind == 1); branch_gt = (kind == 2);
    alu_zero = z; alu_not_zero = nz; alu_greater = gt; pc_plus4_plusimm16 = tgt;
    taken = v && ((kind == 0 && z) || (kind == 1 && nz) || (kind == 2 && gt));
    #1;
    n_checks++; if (pc_src !== taken) $display("FAIL br_pc_src: got %b want %b", pc_src, taken); else n_pass++;
    n_checks++; if (if_flush !== taken) $display("FAIL br_flush: got %b want %b", if_flush, taken); else n_pass++;
    n_checks++; if (branch_target !== tgt) $display("FAIL br_target: got %h want %h", branch_target, tgt); else n_pass++;
    @(posedge clk); @(negedge clk);
    n_checks++; if (wb_reg_wr !== 1'b0) $display("FAIL br_wb_wr: got %b want 0", wb_reg_wr); else n_pass++;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL %s_dmem_req: got %b want 0", tag, dmem_req); else n_pass++;
    n_checks++; if (dmem_we !== 1'b0) $display("FAIL %s_dmem_we: got %b want 0", tag, dmem_we); else n_pass++;
    n_checks++; if (dmem_addr !== 32'h0) $display("FAIL %s_dmem_addr: got %h want 0", tag, dmem_addr); else n_pass++;
    n_checks++; if (dmem_wdata !== 32'h0) $display("FAIL %s_dmem_wdata: got %h want 0", tag, dmem_wdata); else n_pass++;
    n_checks++; if (wb_reg_wr !== 1'b0) $display("FAIL %s_wb_reg_wr: got %b want 0", tag, wb_reg_wr); else n_pass++;
    n_checks++; if (wb_reg_addr !== 5'd0) $display("FAIL %s_wb_reg_addr: got %0d want 0", tag, wb_reg_addr); else n_pass++;
    n_checks++; if (wb_data !== 32'h0) $display("FAIL %s_wb_data: got %h want 0", tag, wb_data); else n_pass++;
`ifdef MEM_STALL_CNT_EN
    n_checks++; if (stall_count !== 32'h0) $display("FAIL %s_stall_count: got %0d want 0", tag, stall_count); else n_pass++;
`endif
  endtask

  task automatic test_reset();
    rstb = 1; clear_inputs();
    @(negedge clk); @(negedge clk);
    check_reset_values("reset");
    n_checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", mem_stall); else n_pass++;
    rstb = 0;
    model_stalls = 0;
  endtask

  task automatic test_alu();
    run_alu(5'd5, 32'h1234, 1'b1);
    run_alu(5'd17, 32'hFFFF_0001, 1'b0);
  endtask

  task automatic test_load();
    mem_model[32'h40] = 32'hDEAD_BEEF;
    run_mem(1'b0, 32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 2);
  endtask

  task automatic test_store();
    run_mem(1'b1, 32'h80, 32'hCAFE, 5'd3, 1'b0, 1'b0, 0);
  endtask

  task automatic test_branch();
    run_branch(1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1);
    run_branch(1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1);
    run_branch(0, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    valid = 1; mem_rd = 1; alu_result = 32'h44; reg_wr = 1; reg_wr_addr = 5'd7; mem_to_reg = 1;
    @(posedge clk); @(negedge clk);
    n_checks++; if (dmem_req !== 1'b1) $display("FAIL rst_wait_pre_req: got %b want 1", dmem_req); else n_pass++;
    rstb = 1;
    #1;
    check_reset_values("rst_wait");
    clear_inputs();
    @(negedge clk);
    rstb = 0;
    model_stalls = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (wb_reg_wr !== 1'b0) $display("FAIL rst_wait_no_wb: got %b want 0", wb_reg_wr); else n_pass++;
      n_checks++; if (dmem_req !== 1'b0) $display("FAIL rst_wait_no_req: got %b want 0", dmem_req); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    run_mem(1'b1, 32'h10, 32'h1111_2222, 5'd0, 1'b0, 1'b0, 1);
    run_mem(1'b0, 32'h10, 32'h0, 5'd12, 1'b1, 1'b1, 0);
    run_alu(5'd13, 32'h5555_AAAA, 1'b1);
  endtask

  task automatic test_stall_count();
`ifdef MEM_STALL_CNT_EN
    test_reset();
    @(negedge clk);
    run_mem(1'b0, 32'h20, 32'h0, 5'd1, 1'b1, 1'b1, 2);
    run_mem(1'b0, 32'h24, 32'h0, 5'd2, 1'b1, 1'b1, 2);
    clear_inputs();
    n_checks++; if (stall_count !== 32'd6) $display("FAIL stall_count_two_loads: got %0d want 6", stall_count); else n_pass++;
`endif
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      a = 32'($urandom_range(0, 15)) << 2;
      case (kind)
        0: run_alu(5'($urandom), $urandom, 1'($urandom));
        1: run_mem(1'b0, a, 32'h0, 5'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
        2: run_mem(1'b1, a, $urandom, 5'($urandom), 1'b0, 1'b0, $urandom_range(0, 3));
        3: run_branch($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'b1);
        default: run_branch($urandom_range(0, 2), 1'b1, 1'b1, 1'b1, $urandom, 1'b0);
      endcase
    end
    clear_inputs();
`ifdef MEM_STALL_CNT_EN
    n_checks++; if (stall_count !== 32'(model_stalls)) $display("FAIL stall_count_random: got %0d want %0d", stall_count, model_stalls); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_reset_mid_wait();
    test_back_to_back();
    test_stall_count();
    test_random();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
